bus_sram_slave: RTL

// Word-addressed SRAM responder for the AHB-Lite-style system bus, the slave end of the CPU data port.

---
 rtl/bus_sram_slave.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bus_sram_slave.sv
// Word-addressed SRAM bus slave: region decode, programmable wait states, two-cycle ERROR response.
// Define SRAM_SLV_STATS_EN to add a read-only hit-transfer counter at BaseAddr+Depth*4.

module bus_sram_slave #(
  parameter int                DWidth     = 32,
  parameter int                Depth      = 256,
  parameter logic [DWidth-1:0] BaseAddr   = 32'h0001_0000,
  parameter int                WaitCycles = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sel_i,
  input  logic              trans_i,
  input  logic              ready_i,
  input  logic              write_i,
  input  logic [DWidth-1:0] addr_i,
  input  logic [DWidth-1:0] wdata_i,
  output logic              ready_o,
  output logic              resp_o,
  output logic [DWidth-1:0] rdata_o
);

  localparam int AW = $clog2(Depth);
  localparam logic [DWidth-1:0] SPAN_MASK = DWidth'(Depth * 4 - 1);
  localparam logic [3:0] WAIT_LOAD = (WaitCycles > 0) ? 4'(WaitCycles - 1) : 4'd0;
  localparam logic WAIT_EN = (WaitCycles > 0) ? 1'b1 : 1'b0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DONE = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]        state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic [AW-1:0]     idx_r, idx_s, rd_idx_s;
  logic              write_r, is_stat_r;
  logic              ready_r, resp_r;
  logic [DWidth-1:0] rdata_r, rd_val_s, stat_fwd_s;
  logic [DWidth-1:0] mem_r [Depth];
  logic              accept_s, hit_s, addr_stat_s, load_s;
  logic              rd_stat_s, rd_is_read_s, rd_load_s, fwd_s, commit_s;

  function automatic logic mem_hit(input logic [DWidth-1:0] a);
    return ((a & ~SPAN_MASK) == BaseAddr) && (a[1:0] == 2'b00);
  endfunction

  assign accept_s = sel_i & trans_i & ready_i;
  assign idx_s    = addr_i[AW+1:2];
  assign hit_s    = mem_hit(addr_i) | addr_stat_s;
  // The counter word never touches the array; its writes are accepted and dropped.
  assign commit_s = (state_r == ST_DONE) & write_r & ~is_stat_r & ~rst_i;

`ifdef SRAM_SLV_STATS_EN
  localparam logic [DWidth-1:0] STAT_ADDR = BaseAddr + DWidth'(Depth * 4);
  logic [31:0] stat_cnt_r;

  assign addr_stat_s = (addr_i == STAT_ADDR);
  // A transfer completing this cycle has not been counted yet; include it so reads see all prior ones.
  assign stat_fwd_s  = DWidth'(stat_cnt_r + ((state_r == ST_DONE) ? 32'd1 : 32'd0));

  // Hit-transfer counter, bumped on every completing DONE cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_cnt_r <= 32'd0;
    end else if (state_r == ST_DONE) begin
      stat_cnt_r <= stat_cnt_r + 32'd1;
    end else begin
      stat_cnt_r <= stat_cnt_r;
    end
  end
`else
  assign addr_stat_s = 1'b0;
  assign stat_fwd_s  = '0;
`endif

  // Next-state and wait-counter logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept_s) begin
          load_s = 1'b1;
          if (!hit_s) begin
            state_nxt_s = ST_ERR1;
          end else if (WAIT_EN) begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = WAIT_LOAD;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_ERR1: state_nxt_s = ST_ERR2;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Read source select, including same-index forwarding from a write committing this edge
  always_comb begin
    if (state_r == ST_WAIT) begin
      rd_idx_s     = idx_r;
      rd_stat_s    = is_stat_r;
      rd_is_read_s = ~write_r;
    end else begin
      rd_idx_s     = idx_s;
      rd_stat_s    = addr_stat_s;
      rd_is_read_s = load_s & ~write_i;
    end
    rd_load_s = (state_nxt_s == ST_DONE) & rd_is_read_s;
    fwd_s     = (state_r == ST_DONE) & write_r & ~is_stat_r & (idx_r == rd_idx_s);
    if (rd_stat_s) begin
      rd_val_s = stat_fwd_s;
    end else if (fwd_s) begin
      rd_val_s = wdata_i;
    end else begin
      rd_val_s = mem_r[rd_idx_s];
    end
  end

  // Control state, latched address phase and registered bus outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      idx_r     <= '0;
      write_r   <= 1'b0;
      is_stat_r <= 1'b0;
      ready_r   <= 1'b1;
      resp_r    <= 1'b0;
      rdata_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (load_s) begin
        idx_r     <= idx_s;
        write_r   <= write_i;
        is_stat_r <= addr_stat_s;
      end
      if (rd_load_s) begin
        rdata_r <= rd_val_s;
      end
      case (state_nxt_s)
        ST_WAIT: begin ready_r <= 1'b0; resp_r <= 1'b0; end
        ST_ERR1: begin ready_r <= 1'b0; resp_r <= 1'b1; end
        ST_ERR2: begin ready_r <= 1'b1; resp_r <= 1'b1; end
        default: begin ready_r <= 1'b1; resp_r <= 1'b0; end
      endcase
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk_i) begin
    if (commit_s) begin
      mem_r[idx_r] <= wdata_i;
    end
  end

  assign ready_o = ready_r;
  assign resp_o  = resp_r;
  assign rdata_o = rdata_r;

endmodule
